// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display reader: glyph table, blank code, FSM encoding.
package ssd_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] d);
        logic [1:0] idx;
        case (d)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; flags legal glyphs and blank.
// Zero latency, no flow control.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        blank  = 1'b0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_reader.sv
// Reads a multiplexed 4-digit seven-segment display; commits a digit after STABLE_CYCLES identical samples.
// Commit visible right after the last stable edge; no backpressure, samples every cycle.
module ssd_reader
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig,
    output logic [15:0] hex,
    output logic [3:0]  valid,
    output logic        upd,
    output logic        err
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] pair_dig_q, pair_dig_d;
    logic [6:0] pair_seg_q, pair_seg_d;
    logic [7:0] count_q, count_d;
    logic       commit;
    logic       usable;
    logic       same;

    logic [3:0] dec_nibble;
    logic       dec_legal;
    logic       dec_blank;
    logic [1:0] commit_idx;

    // At commit time the live sample equals the latched pair, so decoding the input is enough.
    ssd_glyph_decode u_decode (
        .seg    (seg),
        .nibble (dec_nibble),
        .legal  (dec_legal),
        .blank  (dec_blank)
    );

    assign usable     = is_onehot(dig);
    assign same       = usable && (dig == pair_dig_q) && (seg == pair_seg_q);
    assign commit_idx = onehot_index(dig);

    always_comb begin
        state_d    = state_q;
        pair_dig_d = pair_dig_q;
        pair_seg_d = pair_seg_q;
        count_d    = count_q;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (usable) begin
                    pair_dig_d = dig;
                    pair_seg_d = seg;
                    count_d    = 8'd1;
                    state_d    = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (same) begin
                    if (count_q >= CNT_LAST) begin
                        count_d = CNT_FULL;
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (usable) begin
                    pair_dig_d = dig;
                    pair_seg_d = seg;
                    count_d    = 8'd1;
                end else begin
                    count_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Count stays saturated while the pair is stable: no re-commit.
                if (same) begin
                    state_d = ST_HOLD;
                end else if (usable) begin
                    pair_dig_d = dig;
                    pair_seg_d = seg;
                    count_d    = 8'd1;
                    state_d    = ST_TRACK;
                end else begin
                    count_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                count_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pair_dig_q <= 4'd0;
            pair_seg_q <= 7'd0;
            count_q    <= 8'd0;
            hex        <= 16'h0000;
            valid      <= 4'd0;
            upd        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pair_dig_q <= pair_dig_d;
            pair_seg_q <= pair_seg_d;
            count_q    <= count_d;
            upd        <= commit;
            err        <= commit && !dec_legal && !dec_blank;
            if (commit) begin
                if (dec_legal) begin
                    hex[{commit_idx, 2'b00} +: 4] <= dec_nibble;
                end
                valid[commit_idx] <= dec_legal;
            end
        end
    end

endmodule

// File: tb/tb_ssd_reader.sv
// Self-checking bench for ssd_reader: fixed vector table, hand sequences, randomized run vs run-length model.
module tb_ssd_reader;

    localparam int S = 4;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic        upd;
    logic        err;

    ssd_reader #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .seg   (seg),
        .dig   (dig),
        .hex   (hex),
        .valid (valid),
        .upd   (upd),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  d;
        logic [6:0]  s;
        logic [15:0] e_hex;
        logic [3:0]  e_valid;
        logic        e_upd;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: length of the current run of identical one-hot samples; commit when it reaches S.
    logic [15:0] m_hex   = '0;
    logic [3:0]  m_valid = '0;
    logic        m_upd   = 1'b0;
    logic        m_err   = 1'b0;
    int          m_run   = 0;
    logic [3:0]  m_pd    = '0;
    logic [6:0]  m_ps    = '0;

    function automatic void add(input logic r, input logic [3:0] d, input logic [6:0] s,
                                input logic [15:0] eh, input logic [3:0] ev,
                                input logic eu, input logic ee);
        vec_t v;
        v.rst = r; v.d = d; v.s = s;
        v.e_hex = eh; v.e_valid = ev; v.e_upd = eu; v.e_err = ee;
        vecs.push_back(v);
    endfunction

    function automatic void model_edge(input logic r, input logic [3:0] d, input logic [6:0] s);
        int pos;
        int g;
        m_upd = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_hex = '0; m_valid = '0; m_run = 0;
            return;
        end
        if ($countones(d) == 1) begin
            if (m_run > 0 && d == m_pd && s == m_ps) m_run++;
            else m_run = 1;
        end else begin
            m_run = 0;
        end
        m_pd = d;
        m_ps = s;
        if (m_run == S) begin
            m_upd = 1'b1;
            pos = 0;
            for (int i = 0; i < 4; i++) if (d[i]) pos = i;
            g = -1;
            for (int i = 0; i < 16; i++) if (glyphs[i] == s) g = i;
            if (g >= 0) begin
                m_hex[pos*4 +: 4] = 4'(g);
                m_valid[pos] = 1'b1;
            end else begin
                m_valid[pos] = 1'b0;
                if (s != 7'h00) m_err = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic r, input logic [3:0] d, input logic [6:0] s);
        reset = r;
        dig   = d;
        seg   = s;
        @(posedge clk);
        #1;
        model_edge(r, d, s);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " hex"},   hex,          m_hex);
        chk({tag, " valid"}, {12'd0, valid}, {12'd0, m_valid});
        chk({tag, " upd"},   {15'd0, upd}, {15'd0, m_upd});
        chk({tag, " err"},   {15'd0, err}, {15'd0, m_err});
    endtask

    initial begin
        int upd_cnt;
        int err_cnt;
        logic [3:0] rd;
        logic [6:0] rs;
        int len;
        int sel;

        reset = 1'b1;
        dig   = 4'd0;
        seg   = 7'd0;

        // Reset, digit 0 shows "2"
        add(1, 4'b0000, 7'h00, 16'h0000, 4'b0000, 0, 0);
        add(1, 4'b0000, 7'h00, 16'h0000, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0001, 7'h5B, 16'h0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 7'h5B, 16'h0002, 4'b0001, 1, 0);
        add(0, 4'b0001, 7'h5B, 16'h0002, 4'b0001, 0, 0);
        // Digit 2: F for 3 edges then E for 4 -> single commit of E
        for (int i = 0; i < 3; i++) add(0, 4'b0100, 7'h71, 16'h0002, 4'b0001, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0100, 7'h79, 16'h0002, 4'b0001, 0, 0);
        add(0, 4'b0100, 7'h79, 16'h0E02, 4'b0101, 1, 0);
        // Digit 1: 8 committed, then illegal 0x55
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 7'h7F, 16'h0E02, 4'b0101, 0, 0);
        add(0, 4'b0010, 7'h7F, 16'h0E82, 4'b0111, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 7'h55, 16'h0E82, 4'b0111, 0, 0);
        add(0, 4'b0010, 7'h55, 16'h0E82, 4'b0101, 1, 1);
        // Digit 0 blanked: nibble kept, valid cleared, no err
        for (int i = 0; i < 3; i++) add(0, 4'b0001, 7'h00, 16'h0E82, 4'b0101, 0, 0);
        add(0, 4'b0001, 7'h00, 16'h0E82, 4'b0100, 1, 0);
        // Non-one-hot enable never commits
        for (int i = 0; i < 10; i++) add(0, 4'b0011, 7'h3F, 16'h0E82, 4'b0100, 0, 0);
        // An unusable sample in the middle restarts the run
        for (int i = 0; i < 2; i++) add(0, 4'b1000, 7'h06, 16'h0E82, 4'b0100, 0, 0);
        add(0, 4'b0000, 7'h06, 16'h0E82, 4'b0100, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1000, 7'h06, 16'h0E82, 4'b0100, 0, 0);
        add(0, 4'b1000, 7'h06, 16'h1E82, 4'b1100, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].d, vecs[i].s);
            chk($sformatf("vec%0d hex", i),   hex,            vecs[i].e_hex);
            chk($sformatf("vec%0d valid", i), {12'd0, valid}, {12'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d upd", i),   {15'd0, upd},   {15'd0, vecs[i].e_upd});
            chk($sformatf("vec%0d err", i),   {15'd0, err},   {15'd0, vecs[i].e_err});
        end

        // Reset on the edge where a commit would be due, then full run needed again
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1000, 7'h6D);
            chk("pre_reset upd", {15'd0, upd}, 16'd0);
        end
        step(1, 4'b1000, 7'h6D);
        chk("reset_prio upd", {15'd0, upd}, 16'd0);
        chk("reset_prio hex", hex, 16'h0000);
        chk("reset_prio valid", {12'd0, valid}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1000, 7'h6D);
            chk("post_reset early upd", {15'd0, upd}, 16'd0);
        end
        step(0, 4'b1000, 7'h6D);
        chk("post_reset commit upd", {15'd0, upd}, 16'd1);
        chk("post_reset commit hex", hex, 16'h5000);
        chk("post_reset commit valid", {12'd0, valid}, 16'h0008);

        // Long hold: no wrap, no further pulses
        upd_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 4'b1000, 7'h6D);
            if (upd) upd_cnt++;
            if (err) err_cnt++;
        end
        chk("hold50 upd pulses", 16'(upd_cnt), 16'd0);
        chk("hold50 err pulses", 16'(err_cnt), 16'd0);
        chk("hold50 hex", hex, 16'h5000);

        // Randomized bursts checked against the run-length model
        step(1, 4'b0000, 7'h00);
        chk_model("rnd_reset");
        rd = 4'b0001;
        rs = 7'h3F;
        for (int b = 0; b < 400; b++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rd = 4'b0001 << $urandom_range(0, 3);
            else if (sel == 6) rd = 4'b0000;
            else if (sel == 7) rd = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rs = glyphs[$urandom_range(0, 15)];
            else if (sel == 6) rs = 7'h00;
            else if (sel == 7) rs = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                step(($urandom_range(0, 59) == 0), rd, rs);
                chk_model($sformatf("rnd b%0d c%0d", b, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
